demux1_16_scatter: RTL

DEMUX1_16_SCATTER -- requirements
Module: demux1_16_scatter

---
 rtl/demux1_16_scatter.sv | 108 ++++++++++
 1 files changed

// File: rtl/demux1_16_scatter.sv
// Scatters 16 consecutive input words into 16 registered lanes and then holds the frame until acked.
// Latency: an accepted word is visible on its lane 1 cycle after the accepting edge.
// Backpressure: in_ready drops in HOLD and while flush is high. Optional frame counter: SCATTER_FRAME_CNT_EN.
module demux1_16_scatter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [7:0]       wr_index,
`ifdef SCATTER_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    output logic [WIDTH-1:0] out_00,
    output logic [WIDTH-1:0] out_01,
    output logic [WIDTH-1:0] out_02,
    output logic [WIDTH-1:0] out_03,
    output logic [WIDTH-1:0] out_04,
    output logic [WIDTH-1:0] out_05,
    output logic [WIDTH-1:0] out_06,
    output logic [WIDTH-1:0] out_07,
    output logic [WIDTH-1:0] out_08,
    output logic [WIDTH-1:0] out_09,
    output logic [WIDTH-1:0] out_10,
    output logic [WIDTH-1:0] out_11,
    output logic [WIDTH-1:0] out_12,
    output logic [WIDTH-1:0] out_13,
    output logic [WIDTH-1:0] out_14,
    output logic [WIDTH-1:0] out_15
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_nxt;
    logic [3:0]       idx, idx_nxt;
    logic [WIDTH-1:0] lane [16];
    logic             accept;

    always_comb begin
        in_ready  = (state == FILL) && !flush;
        accept    = in_valid && in_ready;
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            FILL: begin
                // flush wins over in_valid: nothing is written on a flush cycle
                if (flush) begin
                    idx_nxt = 4'd0;
                end else if (in_valid) begin
                    idx_nxt = idx + 4'd1;
                    if (idx == 4'd15) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (frame_ack) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= 4'd0;
            for (int i = 0; i < 16; i++) lane[i] <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) lane[idx] <= in_data;
        end
    end

`ifdef SCATTER_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (state == FILL && state_nxt == HOLD) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    assign frame_valid = (state == HOLD);
    assign wr_index    = {4'b0000, idx};

    assign out_00 = lane[0];
    assign out_01 = lane[1];
    assign out_02 = lane[2];
    assign out_03 = lane[3];
    assign out_04 = lane[4];
    assign out_05 = lane[5];
    assign out_06 = lane[6];
    assign out_07 = lane[7];
    assign out_08 = lane[8];
    assign out_09 = lane[9];
    assign out_10 = lane[10];
    assign out_11 = lane[11];
    assign out_12 = lane[12];
    assign out_13 = lane[13];
    assign out_14 = lane[14];
    assign out_15 = lane[15];

endmodule
